// File: rtl/fft_result_receiver_if.sv
// AXI-Stream link carrying FFT output beats from the FFT core to the receiver.
// tdata packs {im, re}, each a DATA_W-bit two's complement component.
interface fft_result_receiver_if #(
  parameter int DATA_W = 16
) ();
  logic [2*DATA_W-1:0] tdata;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  // FFT core side: produces beats, observes backpressure
  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  // Receiver side: consumes beats, drives backpressure
  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface

// File: rtl/fft_result_receiver.sv
// FFT result receiver: consumes one FFT output frame per arm, computes
// re^2+im^2 per bin, tracks the strongest bin inside [BIN_LO, BIN_HI],
// checks frame length against tlast, and hands the peak downstream via
// a level valid / ack handshake.
module fft_result_receiver #(
  parameter int DATA_W    = 16,
  parameter int NFFT_LOG2 = 10,
  parameter int BIN_LO    = 0,
  parameter int BIN_HI    = 511
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    enable,
  fft_result_receiver_if.slave    m_axis_data,
  output logic                    result_valid,
  input  logic                    result_ack,
  output logic [NFFT_LOG2-1:0]    peak_bin,
  output logic [2*DATA_W-1:0]     peak_mag,
  output logic                    tlast_early,
  output logic                    tlast_missing
);

  typedef enum logic [1:0] {IDLE, RECEIVE, DRAIN, RESULT} state_t;

  localparam logic [NFFT_LOG2-1:0] LAST_BIN = '1;

  state_t                     state;
  logic                       tready_reg;
  logic [NFFT_LOG2-1:0]       bin_cnt;
  logic signed [DATA_W-1:0]   re;
  logic signed [DATA_W-1:0]   im;
  logic signed [2*DATA_W-1:0] re_sq;
  logic signed [2*DATA_W-1:0] im_sq;
  logic [2*DATA_W-1:0]        mag;
  logic signed [31:0]         bin_idx;
  logic                       in_window;
  logic                       beat;

  assign m_axis_data.tready = tready_reg;

  // Squares are non-negative and each at most 2**(2*DATA_W-2), so their
  // sum fits in 2*DATA_W unsigned bits even for the most negative inputs.
  assign re    = m_axis_data.tdata[DATA_W-1:0];
  assign im    = m_axis_data.tdata[2*DATA_W-1:DATA_W];
  assign re_sq = re * re;
  assign im_sq = im * im;
  assign mag   = $unsigned(re_sq) + $unsigned(im_sq);

  // Window test done in signed 32-bit space so BIN_LO=0 is not a
  // degenerate unsigned compare.
  assign bin_idx   = 32'(bin_cnt);
  assign in_window = (bin_idx >= BIN_LO) && (bin_idx <= BIN_HI);
  assign beat      = m_axis_data.tvalid && tready_reg;

  // Frame FSM with registered tready/result_valid and peak tracking
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state         <= IDLE;
      tready_reg    <= 1'b0;
      result_valid  <= 1'b0;
      bin_cnt       <= '0;
      peak_bin      <= '0;
      peak_mag      <= '0;
      tlast_early   <= 1'b0;
      tlast_missing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state         <= RECEIVE;
            tready_reg    <= 1'b1;
            bin_cnt       <= '0;
            peak_bin      <= '0;
            peak_mag      <= '0;
            tlast_early   <= 1'b0;
            tlast_missing <= 1'b0;
          end
        end

        RECEIVE: begin
          if (beat) begin
            // Strict compare keeps the lowest index on equal magnitudes
            if (in_window && (mag > peak_mag)) begin
              peak_bin <= bin_cnt;
              peak_mag <= mag;
            end
            bin_cnt <= bin_cnt + 1'b1;
            if (m_axis_data.tlast) begin
              if (bin_cnt != LAST_BIN) begin
                tlast_early <= 1'b1;
              end
              state        <= RESULT;
              tready_reg   <= 1'b0;
              result_valid <= 1'b1;
            end else if (bin_cnt == LAST_BIN) begin
              tlast_missing <= 1'b1;
              state         <= DRAIN;
            end
          end
        end

        DRAIN: begin
          // Overrun beats are swallowed until the stream's own tlast
          if (beat && m_axis_data.tlast) begin
            state        <= RESULT;
            tready_reg   <= 1'b0;
            result_valid <= 1'b1;
          end
        end

        RESULT: begin
          if (result_ack) begin
            state        <= IDLE;
            result_valid <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          tready_reg   <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_result_receiver.sv
// Directed/randomized bench for fft_result_receiver. Two instances share the
// stream stimulus: one searches the full 8-bin frame, one only bins 3..6.
// Expected results come from a frame-level model (first tlast, window max).
module tb_fft_result_receiver;

  localparam int DW = 16;
  localparam int NL = 3;
  localparam int NB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_b;
  logic enable;
  logic result_ack;

  fft_result_receiver_if #(.DATA_W(DW)) ifa ();
  fft_result_receiver_if #(.DATA_W(DW)) ifb ();

  logic            rv_a, rv_b;
  logic [NL-1:0]   pb_a, pb_b;
  logic [2*DW-1:0] pm_a, pm_b;
  logic            te_a, te_b, tm_a, tm_b;

  fft_result_receiver #(.DATA_W(DW), .NFFT_LOG2(NL), .BIN_LO(0), .BIN_HI(7)) dut_a (
    .clk           (clk),
    .reset_b       (reset_b),
    .enable        (enable),
    .m_axis_data   (ifa),
    .result_valid  (rv_a),
    .result_ack    (result_ack),
    .peak_bin      (pb_a),
    .peak_mag      (pm_a),
    .tlast_early   (te_a),
    .tlast_missing (tm_a)
  );

  fft_result_receiver #(.DATA_W(DW), .NFFT_LOG2(NL), .BIN_LO(3), .BIN_HI(6)) dut_b (
    .clk           (clk),
    .reset_b       (reset_b),
    .enable        (enable),
    .m_axis_data   (ifb),
    .result_valid  (rv_b),
    .result_ack    (result_ack),
    .peak_bin      (pb_b),
    .peak_mag      (pm_b),
    .tlast_early   (te_b),
    .tlast_missing (tm_b)
  );

  int checks = 0;
  int errors = 0;

  int f_re [0:15];
  int f_im [0:15];
  bit f_last [0:15];
  int f_len;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: the frame ends at the first tlast within the
  // first NB beats; with none there, all NB beats count and it is overlong.
  task automatic model(input int lo, input int hi, output int bin, output longint mag,
                       output bit early, output bit missing);
    int term;
    longint m;
    term = -1;
    for (int i = 0; i < NB && i < f_len; i++) begin
      if (term < 0 && f_last[i]) term = i;
    end
    early   = (term >= 0) && (term < NB - 1);
    missing = (term < 0);
    if (term < 0) term = NB - 1;
    bin = 0;
    mag = 0;
    for (int i = 0; i <= term; i++) begin
      m = longint'(f_re[i]) * f_re[i] + longint'(f_im[i]) * f_im[i];
      if (i >= lo && i <= hi && m > mag) begin
        mag = m;
        bin = i;
      end
    end
  endtask

  task automatic drive_beat(input int i);
    ifa.tdata  = {16'(f_im[i]), 16'(f_re[i])};
    ifb.tdata  = {16'(f_im[i]), 16'(f_re[i])};
    ifa.tvalid = 1'b1;
    ifb.tvalid = 1'b1;
    ifa.tlast  = f_last[i];
    ifb.tlast  = f_last[i];
  endtask

  task automatic idle_bus();
    ifa.tvalid = 1'b0;
    ifb.tvalid = 1'b0;
    ifa.tlast  = 1'b0;
    ifb.tlast  = 1'b0;
  endtask

  task automatic fill_random(input int len, input int amp);
    f_len = len;
    for (int i = 0; i < 16; i++) begin
      f_re[i]   = $urandom_range(0, 2 * amp) - amp;
      f_im[i]   = $urandom_range(0, 2 * amp) - amp;
      f_last[i] = 1'b0;
    end
    f_last[len - 1] = 1'b1;
  endtask

  // Raise enable (and a stray ack, which must be ignored) until tready shows
  task automatic arm(input string tag);
    int guard;
    guard      = 0;
    enable     = 1'b1;
    result_ack = 1'b1;
    while (ifa.tready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) check({tag, "_arm_timeout"}, 64'(guard), 64'd0);
    enable = 1'b0;
  endtask

  task automatic send_frame(input string tag, input bit gaps);
    int guard;
    for (int i = 0; i < f_len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          idle_bus();
          @(negedge clk);
        end
      end
      drive_beat(i);
      guard = 0;
      while (ifa.tready !== 1'b1 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 10) check({tag, "_beat_timeout"}, 64'(guard), 64'd0);
      @(negedge clk);
    end
    idle_bus();
    result_ack = 1'b0;
  endtask

  // Called on the negedge right after the terminating beat's accept edge
  task automatic finish_frame(input string tag, input bit keep_en);
    int     eb;
    longint em;
    bit     ee, emiss;
    check({tag, "_rv_a"}, 64'(rv_a), 64'd1);
    check({tag, "_rv_b"}, 64'(rv_b), 64'd1);
    check({tag, "_tready_result"}, 64'(ifa.tready), 64'd0);
    @(negedge clk);
    check({tag, "_rv_hold"}, 64'(rv_a), 64'd1);
    model(0, 7, eb, em, ee, emiss);
    check({tag, "_bin_a"}, 64'(pb_a), 64'(eb));
    check({tag, "_mag_a"}, 64'(pm_a), 64'(em));
    check({tag, "_early_a"}, 64'(te_a), 64'(ee));
    check({tag, "_missing_a"}, 64'(tm_a), 64'(emiss));
    model(3, 6, eb, em, ee, emiss);
    check({tag, "_bin_b"}, 64'(pb_b), 64'(eb));
    check({tag, "_mag_b"}, 64'(pm_b), 64'(em));
    check({tag, "_early_b"}, 64'(te_b), 64'(ee));
    check({tag, "_missing_b"}, 64'(tm_b), 64'(emiss));
    $display("frame %s len=%0d peak_a=%0d/%0d peak_b=%0d/%0d early=%0d missing=%0d",
             tag, f_len, pb_a, pm_a, pb_b, pm_b, te_a, tm_a);
    result_ack = 1'b1;
    enable     = keep_en;
    @(negedge clk);
    result_ack = 1'b0;
    check({tag, "_rv_cleared"}, 64'(rv_a), 64'd0);
    check({tag, "_tready_idle"}, 64'(ifa.tready), 64'd0);
    if (keep_en) begin
      @(negedge clk);
      check({tag, "_rearm_tready"}, 64'(ifa.tready), 64'd1);
      enable = 1'b0;
    end
  endtask

  task automatic run(input string tag, input bit gaps, input bit keep_en);
    arm(tag);
    send_frame(tag, gaps);
    finish_frame(tag, keep_en);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_b    = 1'b0;
    enable     = 1'b0;
    result_ack = 1'b0;
    ifa.tdata  = '0;
    ifb.tdata  = '0;
    idle_bus();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tready", 64'(ifa.tready), 64'd0);
    check("rst_rv", 64'(rv_a), 64'd0);
    check("rst_bin", 64'(pb_a), 64'd0);
    check("rst_mag", 64'(pm_a), 64'd0);
    check("rst_flags", 64'({te_a, tm_a, te_b, tm_b}), 64'd0);
    reset_b = 1'b1;
    @(negedge clk);
    check("idle_no_enable", 64'(ifa.tready), 64'd0);

    // Basic frame: bin 5 = (3,-4), others (1,1); enable held to re-arm
    fill_random(8, 0);
    for (int i = 0; i < 8; i++) begin
      f_re[i] = 1;
      f_im[i] = 1;
    end
    f_re[5] = 3;
    f_im[5] = -4;
    run("basic", 1'b0, 1'b1);

    // Tie: bins 2 and 6 both magnitude 10000, others zero
    fill_random(8, 0);
    f_re[2] = -100;
    f_re[6] = -100;
    run("tie", 1'b0, 1'b0);

    // All-zero frame leaves peak at 0/0
    fill_random(8, 0);
    run("zero", 1'b0, 1'b0);

    // Early tlast on beat 4
    fill_random(5, 1000);
    run("early", 1'b0, 1'b0);

    // Missing tlast: 3 extra beats of magnitude 16384, tlast on the third
    fill_random(11, 50);
    for (int i = 8; i < 11; i++) begin
      f_re[i] = 128;
      f_im[i] = 0;
    end
    run("missing", 1'b0, 1'b0);

    // Extreme magnitude on bin 0
    fill_random(8, 32767);
    f_re[0] = -32768;
    f_im[0] = -32768;
    run("extreme", 1'b0, 1'b0);

    // Same random frame without and with tvalid gaps
    fill_random(8, 20000);
    run("nogap", 1'b0, 1'b0);
    run("gap", 1'b1, 1'b0);

    // Reset during beat 3 abandons the frame
    fill_random(8, 100);
    f_re[1] = 30000;
    f_im[1] = 30000;
    arm("abort");
    for (int i = 0; i < 3; i++) begin
      drive_beat(i);
      @(negedge clk);
    end
    drive_beat(3);
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    idle_bus();
    result_ack = 1'b0;
    check("abort_tready", 64'(ifa.tready), 64'd0);
    check("abort_rv", 64'(rv_a), 64'd0);
    check("abort_flags", 64'({te_a, tm_a}), 64'd0);
    check("abort_mag", 64'(pm_a), 64'd0);
    @(negedge clk);
    check("abort_stays_idle", 64'(ifa.tready), 64'd0);
    fill_random(8, 100);
    run("after_abort", 1'b0, 1'b0);

    // Random lengths covering early, exact and overlong frames
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 11);
      fill_random(n, 32767);
      run($sformatf("rand%0d", k), 1'(k % 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
